// File: rtl/fighter_controller_pkg.sv
// Shared fighter constants, state/move codes and the x clamp helper.
package fighter_controller_pkg;

  localparam logic [6:0]        X_INIT        = 7'd24;
  localparam logic [6:0]        X_MIN         = 7'd8;
  localparam logic [6:0]        X_MAX         = 7'd88;
  localparam logic [6:0]        GROUND_Y      = 7'd32;
  localparam logic signed [7:0] STEP          = 8'sd1;
  localparam logic signed [7:0] KNOCKBACK     = 8'sd4;
  localparam logic signed [4:0] JUMP_V        = 5'sd6;
  localparam logic [1:0]        PUNCH_TICKS   = 2'd2;
  localparam logic [1:0]        SPECIAL_TICKS = 2'd3;
  localparam logic [1:0]        INJURED_TICKS = 2'd3;
  localparam logic [3:0]        COMBO_WINDOW  = 4'd8;

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'b000,
    ST_PUNCH   = 3'b001,
    ST_SPECIAL = 3'b010,
    ST_INJURED = 3'b100
  } char_state_t;

  typedef enum logic [1:0] {
    MV_IDLE = 2'b00,
    MV_FWD  = 2'b01,
    MV_BACK = 2'b10
  } move_state_t;

  function automatic logic [6:0] clamp_x(input logic signed [7:0] v);
    if (v < $signed({1'b0, X_MIN})) return X_MIN;
    if (v > $signed({1'b0, X_MAX})) return X_MAX;
    return v[6:0];
  endfunction

endpackage

// File: rtl/fighter_controller_combo_detector.sv
// Tracks progress through the left > down > right part of the special combo.
// Edges advance the step on any clk; idle ticks expire it; clear wins over everything.
module combo_detector
  import fighter_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       left_edge,
  input  logic       right_edge,
  input  logic       down_edge,
  input  logic       up_edge,
  input  logic       clear,
  output logic [1:0] step
);

  logic [3:0] window;
  logic       advance;
  logic       any_edge;

  always_comb begin
    advance  = (step == 2'd0 && left_edge) ||
               (step == 2'd1 && down_edge) ||
               (step == 2'd2 && right_edge);
    any_edge = left_edge | right_edge | down_edge | up_edge;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      step   <= 2'd0;
      window <= 4'd0;
    end else if (advance) begin
      step   <= step + 2'd1;
      window <= 4'd0;
    end else if (any_edge) begin
      // an out-of-order left still counts as a fresh first press
      step   <= left_edge ? 2'd1 : 2'd0;
      window <= 4'd0;
    end else if (tick && step != 2'd0) begin
      if (window + 4'd1 >= COMBO_WINDOW) begin
        step   <= 2'd0;
        window <= 4'd0;
      end else begin
        window <= window + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fighter_controller.sv
// Per-player fighter logic: buttons and hit pulses in, sprite pose/position out.
// Edges and hits are latched every clk and consumed on the next frame tick.
module fighter_controller
  import fighter_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit,
  input  logic [6:0] opponent_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror
);

  logic [4:0]        btn_q;
  logic              left_e, right_e, up_e, down_e, atk_e;
  logic              atk_pend, up_pend, hit_pend;
  logic              atk_p, up_p, hit_p;
  logic [1:0]        step;

  char_state_t       state, state_n;
  logic [1:0]        timer, timer_n;
  logic signed [4:0] vy, vy_n;
  logic [6:0]        x_n, y_n;
  logic              in_air_n, mirror_n;
  move_state_t       move_n;
  logic signed [7:0] xs, x_sum, y_try;

  always_comb begin
    left_e  = btn_left   & ~btn_q[0];
    right_e = btn_right  & ~btn_q[1];
    up_e    = btn_up     & ~btn_q[2];
    down_e  = btn_down   & ~btn_q[3];
    atk_e   = btn_attack & ~btn_q[4];
    atk_p   = atk_pend | atk_e;
    up_p    = up_pend  | up_e;
    hit_p   = hit_pend | hit;
  end

  combo_detector u_combo (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .left_edge  (left_e),
    .right_edge (right_e),
    .down_edge  (down_e),
    .up_edge    (up_e),
    .clear      (tick & atk_p),
    .step       (step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q      <= 5'd0;
      atk_pend   <= 1'b0;
      up_pend    <= 1'b0;
      hit_pend   <= 1'b0;
      state      <= ST_NORMAL;
      timer      <= 2'd0;
      vy         <= 5'sd0;
      x          <= X_INIT;
      y          <= GROUND_Y;
      in_air     <= 1'b0;
      mirror     <= 1'b0;
      move_state <= MV_IDLE;
    end else begin
      btn_q <= {btn_attack, btn_down, btn_up, btn_right, btn_left};
      if (tick) begin
        atk_pend   <= 1'b0;
        up_pend    <= 1'b0;
        hit_pend   <= 1'b0;
        state      <= state_n;
        timer      <= timer_n;
        vy         <= vy_n;
        x          <= x_n;
        y          <= y_n;
        in_air     <= in_air_n;
        mirror     <= mirror_n;
        move_state <= move_n;
      end else begin
        atk_pend <= atk_p;
        up_pend  <= up_p;
        hit_pend <= hit_p;
      end
    end
  end

  // hit > attack > timer expiry
  always_comb begin
    state_n = state;
    timer_n = timer;
    if (hit_p) begin
      state_n = ST_INJURED;
      timer_n = INJURED_TICKS;
    end else if (state == ST_NORMAL) begin
      if (atk_p) begin
        state_n = (step == 2'd3) ? ST_SPECIAL : ST_PUNCH;
        timer_n = (step == 2'd3) ? SPECIAL_TICKS : PUNCH_TICKS;
      end
    end else begin
      timer_n = timer - 2'd1;
      if (timer_n == 2'd0) state_n = ST_NORMAL;
    end
  end

  always_comb begin
    if (opponent_x < x)      mirror_n = 1'b1;
    else if (opponent_x > x) mirror_n = 1'b0;
    else                     mirror_n = mirror;

    xs     = $signed({1'b0, x});
    x_sum  = xs;
    move_n = MV_IDLE;
    if (hit_p) begin
      x_sum = mirror_n ? xs + KNOCKBACK : xs - KNOCKBACK;
    end else if (state == ST_NORMAL && state_n == ST_NORMAL && (btn_left ^ btn_right)) begin
      x_sum  = btn_right ? xs + STEP : xs - STEP;
      move_n = (btn_left == mirror_n) ? MV_FWD : MV_BACK;
    end
    x_n = clamp_x(x_sum);

    y_try    = $signed({1'b0, y}) - {{3{vy[4]}}, vy};
    y_n      = y;
    vy_n     = vy;
    in_air_n = in_air;
    if (in_air) begin
      if (y_try >= $signed({1'b0, GROUND_Y})) begin
        y_n      = GROUND_Y;
        in_air_n = 1'b0;
        vy_n     = 5'sd0;
      end else begin
        y_n  = y_try[6:0];
        vy_n = vy - 5'sd1;
      end
    end else if (up_p && state == ST_NORMAL && !hit_p) begin
      in_air_n = 1'b1;
      vy_n     = JUMP_V;
    end
  end

  assign character_state = state;

endmodule

// File: tb/tb_fighter_controller.sv
// Directed bench for fighter_controller with a tick-level reference model.
module tb_fighter_controller;

  logic       clk = 1'b0;
  logic       reset, tick, btn_left, btn_right, btn_up, btn_down, btn_attack, hit;
  logic [6:0] opponent_x;
  logic [6:0] x, y;
  logic       in_air, mirror;
  logic [1:0] move_state;
  logic [2:0] character_state;

  fighter_controller dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_attack(btn_attack), .hit(hit),
    .opponent_x(opponent_x), .x(x), .y(y), .in_air(in_air),
    .move_state(move_state), .character_state(character_state), .mirror(mirror)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position/state per tick, jump height from the closed-form parabola
  int mx, my, mair, mmove, mstate, mtime, mmir, jt, hgt, mstep, tk, adv_tk, so;
  bit p_atk, p_up, p_hit, pl, pr, pu, pd, pa;
  bit le, re, ue, de, ae, a, u, h;

  function automatic int clampm(input int v);
    return (v < 8) ? 8 : ((v > 88) ? 88 : v);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mx = 24; my = 32; mair = 0; mmove = 0; mstate = 0; mmir = 0; mtime = 0;
      jt = 0; mstep = 0; tk = 0; adv_tk = 0;
      p_atk = 0; p_up = 0; p_hit = 0; pl = 0; pr = 0; pu = 0; pd = 0; pa = 0;
    end else begin
      le = btn_left && !pl; re = btn_right && !pr; ue = btn_up && !pu;
      de = btn_down && !pd; ae = btn_attack && !pa;
      pl = btn_left; pr = btn_right; pu = btn_up; pd = btn_down; pa = btn_attack;
      a = p_atk || ae; u = p_up || ue; h = p_hit || hit;
      so = mstep;
      if (tick) begin
        tk++;
        if (opponent_x < mx) mmir = 1;
        else if (opponent_x > mx) mmir = 0;
        mmove = 0;
        if (mair != 0) begin
          jt++;
          hgt = 6 * jt - jt * (jt - 1) / 2;
          if (hgt <= 0) begin mair = 0; my = 32; end
          else my = 32 - hgt;
        end else if (u && mstate == 0 && !h) begin
          mair = 1; jt = 0;
        end
        if (h) begin
          mstate = 4; mtime = 3;
          mx = clampm(mmir != 0 ? mx + 4 : mx - 4);
        end else if (mstate == 0) begin
          if (a) begin
            mstate = (so == 3) ? 2 : 1;
            mtime  = (so == 3) ? 3 : 2;
          end else if (btn_left != btn_right) begin
            mx = clampm(btn_right ? mx + 1 : mx - 1);
            mmove = ((btn_right == 1'b1) == (mmir == 0)) ? 1 : 2;
          end
        end else begin
          mtime--;
          if (mtime == 0) mstate = 0;
        end
        p_atk = 0; p_up = 0; p_hit = 0;
        if (a) mstep = 0;
      end else begin
        p_atk = a; p_up = u; p_hit = h;
      end
      if (!(tick && a)) begin
        if (le || re || de || ue) begin
          if ((so == 0 && le) || (so == 1 && de) || (so == 2 && re)) mstep = so + 1;
          else mstep = le ? 1 : 0;
          adv_tk = tk;
        end else if (tick && mstep != 0 && tk - adv_tk >= 8) begin
          mstep = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x", x, mx);
      chk("y", y, my);
      chk("in_air", in_air, mair);
      chk("move_state", move_state, mmove);
      chk("character_state", character_state, mstate);
      chk("mirror", mirror, mmir);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 0; cyc(); cyc();
      tick = 1; cyc();
      tick = 0;
    end
  endtask

  task automatic press_up();     btn_up = 1;     cyc(); btn_up = 0;     cyc(); endtask
  task automatic press_down();   btn_down = 1;   cyc(); btn_down = 0;   cyc(); endtask
  task automatic press_left();   btn_left = 1;   cyc(); btn_left = 0;   cyc(); endtask
  task automatic press_right();  btn_right = 1;  cyc(); btn_right = 0;  cyc(); endtask
  task automatic press_attack(); btn_attack = 1; cyc(); btn_attack = 0; cyc(); endtask

  task automatic combo(input int gap);
    press_left();  ticks(3);
    press_down();  ticks(3);
    press_right(); ticks(gap);
    press_attack(); ticks(1);
  endtask

  initial begin
    reset = 1; tick = 0; hit = 0; opponent_x = 7'd80;
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_attack = 0;
    cyc(); chk_en = 1; cyc();
    reset = 0;
    chk("reset_x", x, 24);
    chk("reset_y", y, 32);
    chk("reset_state", character_state, 0);

    // walk right, then flip facing
    btn_right = 1; ticks(10);
    chk("walk_x", x, 34);
    chk("walk_move_fwd", move_state, 1);
    chk("walk_mirror0", mirror, 0);
    opponent_x = 7'd10; ticks(1);
    chk("flip_mirror1", mirror, 1);
    chk("flip_move_back", move_state, 2);
    btn_right = 0; ticks(1);

    // jump arc, with an ignored mid-air up
    press_up(); ticks(1);
    chk("jump_in_air", in_air, 1);
    ticks(6);
    chk("jump_apex_y", y, 11);
    press_up(); ticks(7);
    chk("land_y", y, 32);
    chk("land_in_air", in_air, 0);
    ticks(1);
    chk("no_rejump", in_air, 0);

    // punch, with a second attack ignored
    press_attack(); ticks(1);
    chk("punch_1", character_state, 1);
    press_attack(); ticks(1);
    chk("punch_2", character_state, 1);
    ticks(1);
    chk("punch_done", character_state, 0);
    ticks(1);
    chk("punch_not_queued", character_state, 0);

    // special combo inside and outside the window
    combo(3);
    chk("special_1", character_state, 2);
    ticks(2);
    chk("special_3", character_state, 2);
    ticks(1);
    chk("special_done", character_state, 0);
    combo(9);
    chk("combo_expired_punch", character_state, 1);
    ticks(2);

    // knockback clamp and injured timer restart
    opponent_x = 7'd100;
    btn_left = 1; ticks(25); btn_left = 0;
    chk("walk_left_x", x, 10);
    press_attack(); ticks(1);
    hit = 1; cyc(); hit = 0; ticks(1);
    chk("injured", character_state, 4);
    chk("knockback_clamp", x, 8);
    hit = 1; cyc(); hit = 0; ticks(1);
    ticks(2);
    chk("injured_restart", character_state, 4);
    ticks(1);
    chk("injured_done", character_state, 0);

    // reset mid-jump, coinciding with a tick
    press_up(); ticks(3);
    chk("mid_jump_y", y, 21);
    tick = 1; reset = 1; cyc(); reset = 0; tick = 0;
    chk("rst_y", y, 32);
    chk("rst_in_air", in_air, 0);
    chk("rst_x", x, 24);
    chk("rst_state", character_state, 0);
    ticks(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
